// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two dmem requesters, the arbiter and the data memory.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              ext_lock;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ext_lock, mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_write, mem_addr, mem_wdata
  );

  // Requester/memory side
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ext_lock, mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing dmem between the core (port 0) and an external requester (port 1).
// Define DMEM_ARB_STATS_EN to add the saturating conflict_cnt stall counter output.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int unsigned HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_winner_q, last_winner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              ack0_c, ack1_c, hold_expired_c;
  logic [HOLD_W-1:0] hold_inc_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      last_winner_q <= 1'b1;
      hold_cnt_q    <= HOLD_W'(0);
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // Next-state, hold accounting and memory mux, all keyed off the registered grant
  always_comb begin
    state_d        = state_q;
    last_winner_d  = last_winner_q;
    hold_cnt_d     = hold_cnt_q;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = ADDR_W'(0);
    bus.mem_wdata  = DATA_W'(0);

    ack0_c         = (state_q == S_GNT0) && bus.req0;
    ack1_c         = (state_q == S_GNT1) && bus.req1;
    hold_expired_c = (hold_cnt_q >= HOLD_W'(HOLD_LAST));
    hold_inc_c     = hold_expired_c ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

    bus.ack0   = ack0_c;
    bus.ack1   = ack1_c;
    bus.rdata0 = ack0_c ? bus.mem_rdata : DATA_W'(0);
    bus.rdata1 = ack1_c ? bus.mem_rdata : DATA_W'(0);

    case (state_q)
      S_IDLE: begin
        hold_cnt_d = HOLD_W'(0);
        if (bus.req0 && bus.req1) state_d = last_winner_q ? S_GNT0 : S_GNT1;
        else if (bus.req0)        state_d = S_GNT0;
        else if (bus.req1)        state_d = S_GNT1;
      end
      S_GNT0: begin
        bus.mem_addr  = bus.addr0;
        bus.mem_wdata = bus.wdata0;
        bus.mem_write = ack0_c && bus.we0;
        if (bus.req0 && (!bus.req1 || !hold_expired_c)) begin
          hold_cnt_d = bus.req1 ? hold_inc_c : HOLD_W'(0);
        end else if (bus.req1) begin
          state_d    = S_GNT1;
          hold_cnt_d = HOLD_W'(0);
        end else begin
          state_d    = S_IDLE;
          hold_cnt_d = HOLD_W'(0);
        end
      end
      S_GNT1: begin
        bus.mem_addr  = bus.addr1;
        bus.mem_wdata = bus.wdata1;
        bus.mem_write = ack1_c && bus.we1;
        // ext_lock lets the external port hold the memory past MAX_HOLD
        if (bus.req1 && (!bus.req0 || !hold_expired_c || bus.ext_lock)) begin
          hold_cnt_d = bus.req0 ? hold_inc_c : HOLD_W'(0);
        end else if (bus.req0) begin
          state_d    = S_GNT0;
          hold_cnt_d = HOLD_W'(0);
        end else begin
          state_d    = S_IDLE;
          hold_cnt_d = HOLD_W'(0);
        end
      end
      default: begin
        state_d    = S_IDLE;
        hold_cnt_d = HOLD_W'(0);
      end
    endcase

    if (ack0_c)      last_winner_d = 1'b0;
    else if (ack1_c) last_winner_d = 1'b1;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Counts cycles where any requester is left waiting
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (((bus.req0 && !ack0_c) || (bus.req1 && !ack1_c)) && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_cnt_q <= 16'd0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic vs a cycle model.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_HOLD = 8;
  localparam int          MEM_N    = 32;

  logic clk = 1'b0;
  logic reset;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write at the clock edge
  logic [31:0] mem [MEM_N];
  assign bus.mem_rdata = mem[bus.mem_addr[4:0]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;

  // Reference model state: who owns the memory, contended run length, last winner
  int          own;
  int          run;
  bit          lw;
  int          m_conf;
  logic [31:0] ref_mem [MEM_N];

  int total = 0;
  int bad   = 0;
  logic        obs_ack0, obs_ack1;
  logic [31:0] obs_rd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; run = 0; lw = 1'b1; m_conf = 0;
  endtask

  // One clock cycle: compare outputs to the model at negedge, then advance the model
  task automatic tick();
    logic        e_ack0, e_ack1, e_mw, ri, rj;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    int          i;
    @(negedge clk);
    e_ack0 = (own == 0) && bus.req0;
    e_ack1 = (own == 1) && bus.req1;
    e_addr = (own == 0) ? bus.addr0  : (own == 1) ? bus.addr1  : 32'd0;
    e_wd   = (own == 0) ? bus.wdata0 : (own == 1) ? bus.wdata1 : 32'd0;
    e_mw   = (e_ack0 && bus.we0) || (e_ack1 && bus.we1);
    e_rd0  = e_ack0 ? ref_mem[bus.addr0[4:0]] : 32'd0;
    e_rd1  = e_ack1 ? ref_mem[bus.addr1[4:0]] : 32'd0;
    check("ack0", bus.ack0, e_ack0);
    check("ack1", bus.ack1, e_ack1);
    check("mem_write", bus.mem_write, e_mw);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wd);
    check("rdata0", bus.rdata0, e_rd0);
    check("rdata1", bus.rdata1, e_rd1);
`ifdef DMEM_ARB_STATS_EN
    check("conflict_cnt", conflict_cnt, m_conf);
    if (((bus.req0 && !e_ack0) || (bus.req1 && !e_ack1)) && m_conf < 65535) m_conf++;
`endif
    obs_ack0 = bus.ack0;
    obs_ack1 = bus.ack1;
    obs_rd0  = bus.rdata0;
    if (e_mw) ref_mem[e_addr[4:0]] = e_wd;
    if (e_ack0) lw = 1'b0;
    if (e_ack1) lw = 1'b1;
    if (own < 0) begin
      run = 0;
      if (bus.req0 && bus.req1) own = lw ? 0 : 1;
      else if (bus.req0)        own = 0;
      else if (bus.req1)        own = 1;
    end else begin
      i  = own;
      ri = (i == 0) ? bus.req0 : bus.req1;
      rj = (i == 0) ? bus.req1 : bus.req0;
      if (ri && (!rj || run + 1 < int'(MAX_HOLD) || (i == 1 && bus.ext_lock))) begin
        run = rj ? run + 1 : 0;
      end else if (rj) begin
        own = 1 - i; run = 0;
      end else begin
        own = -1; run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'd0; bus.wdata0 = 32'd0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 32'd0; bus.wdata1 = 32'd0;
    bus.ext_lock = 1'b0;
  endtask

  // Random requester that honours hold-until-ack, with occasional aborts
  task automatic rand_port(inout logic req, inout logic we, inout logic [31:0] addr,
                           inout logic [31:0] wdata, input logic acked);
    if (req && acked) req = 1'b0;
    else if (req && $urandom_range(0, 99) < 3) req = 1'b0;
    if (!req && $urandom_range(0, 1) == 1) begin
      req   = 1'b1;
      we    = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, MEM_N - 1));
      wdata = $urandom;
    end
  endtask

  initial begin
    logic        r, w;
    logic [31:0] a, d;
    bit          got_gnt;
    for (int k = 0; k < MEM_N; k++) begin
      mem[k]     = 32'(k) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[k] = 32'(k) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    idle_inputs();
    model_reset();
    obs_ack0 = 1'b0; obs_ack1 = 1'b0; obs_rd0 = 32'd0;
    reset = 1'b0;
    #12;
    check("rst_ack0", bus.ack0, 0);
    check("rst_ack1", bus.ack1, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
`ifdef DMEM_ARB_STATS_EN
    check("rst_conflict", conflict_cnt, 0);
`endif
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Single write then read-back on the core port
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEAD_BEEF;
    tick(); check("t2_first_cycle_wait", obs_ack0, 0);
    tick(); check("t2_write_ack", obs_ack0, 1);
    check("t2_mem_written", mem[16], 32'hDEAD_BEEF);
    bus.we0 = 1'b0;
    tick(); check("t2_read_ack", obs_ack0, 1);
    check("t2_read_data", obs_rd0, 32'hDEAD_BEEF);

    // Reset asserted while a write is being presented
    bus.we0 = 1'b1; bus.addr0 = 32'd5; bus.wdata0 = 32'h1234_5678;
    #1 check("t1_write_live", bus.mem_write, 1);
    reset = 1'b0;
    #1;
    check("t1_write_dropped", bus.mem_write, 0);
    check("t1_ack0_dropped", bus.ack0, 0);
    check("t1_addr_zero", bus.mem_addr, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk) reset = 1'b1;
    model_reset();
    check("t1_mem_unchanged", mem[5], ref_mem[5]);
    @(posedge clk); #1;

    // Contention from idle: core first, then 8/8 alternation
    bus.req0 = 1'b1; bus.addr0 = 32'd3;
    bus.req1 = 1'b1; bus.addr1 = 32'd7;
    tick(); check("t3_idle_no_ack", {obs_ack0, obs_ack1}, 2'b00);
    for (int k = 0; k < 24; k++) begin
      tick();
      check($sformatf("t3_ack0_c%0d", k), obs_ack0, ((k / 8) % 2) == 0);
      check($sformatf("t3_ack1_c%0d", k), obs_ack1, ((k / 8) % 2) == 1);
    end

    // External lock holds the grant beyond MAX_HOLD
    bus.ext_lock = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t4_locked_ack1", obs_ack1, 1);
      check("t4_locked_ack0", obs_ack0, 0);
    end
    bus.ext_lock = 1'b0;
    tick(); check("t4_drop_cycle_ack1", obs_ack1, 1);
    tick(); check("t4_core_regains", obs_ack0, 1);

    // Holder drops its request while the other waits, then both go quiet
    bus.req0 = 1'b0;
    tick(); check("t5_drop_no_ack", {obs_ack0, obs_ack1}, 2'b00);
    tick(); check("t5_other_acked", obs_ack1, 1);
    bus.req1 = 1'b0;
    tick(); check("t5_both_idle_a", {obs_ack0, obs_ack1}, 2'b00);
    tick(); check("t5_both_idle_b", {obs_ack0, obs_ack1}, 2'b00);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.wdata1 = 32'hCAFE_0001;
    tick(); check("t5_idle_latency", obs_ack1, 0);
    tick(); check("t5_ext_write_ack", obs_ack1, 1);
    idle_inputs();
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r = bus.req0; w = bus.we0; a = bus.addr0; d = bus.wdata0;
      rand_port(r, w, a, d, obs_ack0);
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
      r = bus.req1; w = bus.we1; a = bus.addr1; d = bus.wdata1;
      rand_port(r, w, a, d, obs_ack1);
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
      if ($urandom_range(0, 19) == 0) bus.ext_lock = ~bus.ext_lock;
      tick();
    end
    idle_inputs();
    tick();

`ifdef DMEM_ARB_STATS_EN
    // Long lock starves the core to drive the stall counter into saturation
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.ext_lock = 1'b1;
    got_gnt = 1'b0;
    for (int k = 0; k < 40 && !got_gnt; k++) begin
      tick();
      got_gnt = obs_ack1;
    end
    check("t6_lock_grant_reached", got_gnt, 1);
    for (int k = 0; k < 65540; k++) tick();
    check("t6_saturated", conflict_cnt, 16'hFFFF);
    idle_inputs();
    tick();
`else
    got_gnt = 1'b0;
`endif

    for (int k = 0; k < MEM_N; k++) check($sformatf("mem_final_%0d", k), mem[k], ref_mem[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
